// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: safety monitor between the traffic-light controller
// and the lamp pin drivers. It forwards lamps with one cycle of latency and
// checks every monitored cycle for conflicting greens, malformed codes,
// illegal colour sequences and (optionally) short amber phases. On a fault it
// latches the first fault code and flashes amber on both streets until
// fault_clr, then holds all-red for ALL_RED cycles before monitoring again.
//
// Optional feature macro: TRAFFIC_LAMP_MON_AMBER_CHECK_EN
//   defined   -> per-street amber run counters and fault codes 6/7 built in
//   undefined -> no amber counters, codes 6/7 never raised
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   street_a/_b [2:0]         controller lamp codes {red, amber, green}
//   street_a/_b_pri_lamp      controller priority lamps
//   fault_clr                 single-cycle clear request (honoured in FAULT)
//   lamp_a/_b [2:0]           driven lamp codes (registered)
//   lamp_a/_b_pri             driven priority lamps (registered)
//   fault, fault_code [3:0]   latched fault flag and first fault code
module traffic_lamp_monitor #(
  parameter int unsigned ALL_RED    = 4,
  parameter int unsigned MIN_AMBER  = 3,
  parameter int unsigned FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] street_a,
  input  logic       street_a_pri_lamp,
  input  logic [2:0] street_b,
  input  logic       street_b_pri_lamp,
  input  logic       fault_clr,
  output logic [2:0] lamp_a,
  output logic       lamp_a_pri,
  output logic [2:0] lamp_b,
  output logic       lamp_b_pri,
  output logic       fault,
  output logic [3:0] fault_code
);

  localparam int unsigned AR_W = $clog2(ALL_RED + 1);
  localparam int unsigned FL_W = $clog2(FLASH_HALF + 1);
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_MONITOR,
    ST_FAULT,
    ST_RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [AR_W-1:0] ar_cnt_q, ar_cnt_d;
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
  logic            fl_dark_q, fl_dark_d;
  logic            hist_vld_q, hist_vld_d;
  logic [2:0]      prev_a_q, prev_a_d;
  logic [2:0]      prev_b_q, prev_b_d;
  logic [2:0]      lamp_a_q, lamp_a_d;
  logic [2:0]      lamp_b_q, lamp_b_d;
  logic            lamp_a_pri_q, lamp_a_pri_d;
  logic            lamp_b_pri_q, lamp_b_pri_d;
  logic            fault_q, fault_d;
  logic [3:0]      fault_code_q, fault_code_d;
  logic [3:0]      viol_code_c;
  logic            short_a_c, short_b_c;

`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
  localparam int unsigned AM_W = $clog2(MIN_AMBER + 1);
  logic [AM_W-1:0] amb_a_q, amb_a_d;
  logic [AM_W-1:0] amb_b_q, amb_b_d;

  // Amber run counter: counts consecutive amber cycles, saturating at MIN_AMBER.
  function automatic logic [AM_W-1:0] amb_next(input logic is_amber,
                                               input logic [AM_W-1:0] run);
    if (!is_amber)                          return '0;
    else if (run >= AM_W'(MIN_AMBER))       return AM_W'(MIN_AMBER);
    else                                    return run + AM_W'(1);
  endfunction

  // Amber that ended (into red) before reaching the minimum run.
  assign short_a_c = hist_vld_q & prev_a_q[1] & street_a[2] & (amb_a_q < AM_W'(MIN_AMBER));
  assign short_b_c = hist_vld_q & prev_b_q[1] & street_b[2] & (amb_b_q < AM_W'(MIN_AMBER));
`else
  assign short_a_c = 1'b0;
  assign short_b_c = 1'b0;
`endif

  // Forbidden colour steps: green->red, red->amber, amber->green.
  function automatic logic bad_step(input logic [2:0] prev, input logic [2:0] cur);
    return (prev[0] & cur[2]) | (prev[2] & cur[1]) | (prev[1] & cur[0]);
  endfunction

  // Violation code for the current inputs; lowest code number wins.
  always_comb begin
    viol_code_c = 4'd0;
    if (!$onehot(street_a))                                     viol_code_c = 4'd1;
    else if (!$onehot(street_b))                                viol_code_c = 4'd2;
    else if (!street_a[2] && !street_b[2])                      viol_code_c = 4'd3;
    else if (hist_vld_q && bad_step(prev_a_q, street_a))        viol_code_c = 4'd4;
    else if (hist_vld_q && bad_step(prev_b_q, street_b))        viol_code_c = 4'd5;
    else if (short_a_c)                                         viol_code_c = 4'd6;
    else if (short_b_c)                                         viol_code_c = 4'd7;
    else if ((street_a_pri_lamp && !street_a[0]) ||
             (street_b_pri_lamp && !street_b[0]))               viol_code_c = 4'd8;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ar_cnt_d     = ar_cnt_q;
    fl_cnt_d     = fl_cnt_q;
    fl_dark_d    = fl_dark_q;
    hist_vld_d   = hist_vld_q;
    prev_a_d     = prev_a_q;
    prev_b_d     = prev_b_q;
    lamp_a_d     = lamp_a_q;
    lamp_b_d     = lamp_b_q;
    lamp_a_pri_d = lamp_a_pri_q;
    lamp_b_pri_d = lamp_b_pri_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
    amb_a_d      = amb_a_q;
    amb_b_d      = amb_b_q;
`endif

    unique case (state_q)
      ST_STARTUP, ST_RECOVER: begin
        lamp_a_d     = LAMP_RED;
        lamp_b_d     = LAMP_RED;
        lamp_a_pri_d = 1'b0;
        lamp_b_pri_d = 1'b0;
        hist_vld_d   = 1'b0;
`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
        amb_a_d      = '0;
        amb_b_d      = '0;
`endif
        if (ar_cnt_q == AR_W'(ALL_RED - 1)) begin
          ar_cnt_d = '0;
          state_d  = ST_MONITOR;
        end else begin
          ar_cnt_d = ar_cnt_q + AR_W'(1);
        end
      end

      ST_MONITOR: begin
        if (viol_code_c != 4'd0) begin
          // Violating inputs are never forwarded; flashing starts on amber.
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = viol_code_c;
          lamp_a_d     = LAMP_AMBER;
          lamp_b_d     = LAMP_AMBER;
          lamp_a_pri_d = 1'b0;
          lamp_b_pri_d = 1'b0;
          fl_cnt_d     = '0;
          fl_dark_d    = 1'b0;
        end else begin
          lamp_a_d     = street_a;
          lamp_b_d     = street_b;
          lamp_a_pri_d = street_a_pri_lamp;
          lamp_b_pri_d = street_b_pri_lamp;
          prev_a_d     = street_a;
          prev_b_d     = street_b;
          hist_vld_d   = 1'b1;
`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
          amb_a_d      = amb_next(street_a[1], amb_a_q);
          amb_b_d      = amb_next(street_b[1], amb_b_q);
`endif
        end
      end

      ST_FAULT: begin
        lamp_a_pri_d = 1'b0;
        lamp_b_pri_d = 1'b0;
        if (fault_clr) begin
          state_d      = ST_RECOVER;
          fault_d      = 1'b0;
          fault_code_d = 4'd0;
          ar_cnt_d     = '0;
          lamp_a_d     = LAMP_RED;
          lamp_b_d     = LAMP_RED;
        end else begin
          if (fl_cnt_q == FL_W'(FLASH_HALF - 1)) begin
            fl_cnt_d  = '0;
            fl_dark_d = ~fl_dark_q;
          end else begin
            fl_cnt_d  = fl_cnt_q + FL_W'(1);
          end
          lamp_a_d = fl_dark_d ? 3'b000 : LAMP_AMBER;
          lamp_b_d = fl_dark_d ? 3'b000 : LAMP_AMBER;
        end
      end

      default: state_d = ST_STARTUP;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STARTUP;
      ar_cnt_q     <= '0;
      fl_cnt_q     <= '0;
      fl_dark_q    <= 1'b0;
      hist_vld_q   <= 1'b0;
      prev_a_q     <= 3'b000;
      prev_b_q     <= 3'b000;
      lamp_a_q     <= LAMP_RED;
      lamp_b_q     <= LAMP_RED;
      lamp_a_pri_q <= 1'b0;
      lamp_b_pri_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 4'd0;
`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
      amb_a_q      <= '0;
      amb_b_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ar_cnt_q     <= ar_cnt_d;
      fl_cnt_q     <= fl_cnt_d;
      fl_dark_q    <= fl_dark_d;
      hist_vld_q   <= hist_vld_d;
      prev_a_q     <= prev_a_d;
      prev_b_q     <= prev_b_d;
      lamp_a_q     <= lamp_a_d;
      lamp_b_q     <= lamp_b_d;
      lamp_a_pri_q <= lamp_a_pri_d;
      lamp_b_pri_q <= lamp_b_pri_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
`ifdef TRAFFIC_LAMP_MON_AMBER_CHECK_EN
      amb_a_q      <= amb_a_d;
      amb_b_q      <= amb_b_d;
`endif
    end
  end

  assign lamp_a     = lamp_a_q;
  assign lamp_b     = lamp_b_q;
  assign lamp_a_pri = lamp_a_pri_q;
  assign lamp_b_pri = lamp_b_pri_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
